// File: rtl/pong_pixel_scanner.sv
// Raster scan master for the Pong LCD path: walks every (x,y), waits for the
// renderers' draw flags to settle, and hands one prioritised RGB565 word per pixel to the LCD.
module pong_pixel_scanner #(
   parameter int unsigned WIDTH         = 240,
   parameter int unsigned HEIGHT        = 320,
   parameter int unsigned DRAW_LATENCY  = 1,
   parameter logic [15:0] BALL_COLOUR   = 16'hFFFF,
   parameter logic [15:0] PADDLE_COLOUR = 16'h07E0,
   parameter logic [15:0] BG_COLOUR     = 16'h0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        frameRequest,
   input  logic        drawBall,
   input  logic        drawPaddle,
   input  logic        pixelReady,
   output logic [7:0]  xCount,
   output logic [8:0]  yCount,
   output logic        pixelWrite,
   output logic [15:0] pixelData,
   output logic        frameStart,
   output logic        frameDone,
   output logic        busy
);

   localparam int unsigned CNT_W = $clog2(DRAW_LATENCY + 1);
   localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(DRAW_LATENCY - 1);
   localparam logic [7:0] X_LAST = 8'(WIDTH - 1);
   localparam logic [8:0] Y_LAST = 9'(HEIGHT - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SETTLE,
      ST_WRITE,
      ST_FRAME_END
   } state_e;

   state_e           state_q;
   logic [CNT_W-1:0] settle_q;
   logic [7:0]       x_q;
   logic [8:0]       y_q;
   logic             write_q;
   logic [15:0]      data_q;
   logic             start_q;
   logic             done_q;
   logic             busy_q;
   logic [15:0]      colour_d;

   // Ball overrides paddle, paddle overrides background.
   always_comb begin
      colour_d = BG_COLOUR;
      if (drawBall)
         colour_d = BALL_COLOUR;
      else if (drawPaddle)
         colour_d = PADDLE_COLOUR;
   end

   // NOTE: every register here is assigned with <= so all of them update from the
   // same pre-edge values; mixing in blocking assignments would make the order of statements matter.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= ST_IDLE;
         settle_q <= '0;
         x_q      <= '0;
         y_q      <= '0;
         write_q  <= 1'b0;
         data_q   <= BG_COLOUR;
         start_q  <= 1'b0;
         done_q   <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         start_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (frameRequest) begin
                  state_q  <= ST_SETTLE;
                  x_q      <= '0;
                  y_q      <= '0;
                  settle_q <= '0;
                  start_q  <= 1'b1;
                  busy_q   <= 1'b1;
               end
            end

            ST_SETTLE: begin
               settle_q <= settle_q + CNT_W'(1);
               if (settle_q == SETTLE_LAST) begin
                  state_q <= ST_WRITE;
                  data_q  <= colour_d;
                  write_q <= 1'b1;
               end
            end

            // pixelWrite is always high here, so pixelReady alone marks a transfer.
            ST_WRITE: begin
               if (pixelReady) begin
                  write_q  <= 1'b0;
                  settle_q <= '0;
                  if (x_q != X_LAST) begin
                     x_q     <= x_q + 8'd1;
                     state_q <= ST_SETTLE;
                  end else if (y_q != Y_LAST) begin
                     x_q     <= '0;
                     y_q     <= y_q + 9'd1;
                     state_q <= ST_SETTLE;
                  end else begin
                     state_q <= ST_FRAME_END;
                  end
               end
            end

            // Two cycles: raise frameDone, then drop it while still busy so a
            // request coinciding with frameDone cannot start a new scan.
            ST_FRAME_END: begin
               x_q <= '0;
               y_q <= '0;
               if (!done_q) begin
                  done_q <= 1'b1;
               end else begin
                  done_q  <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end
            end

            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign xCount     = x_q;
   assign yCount     = y_q;
   assign pixelWrite = write_q;
   assign pixelData  = data_q;
   assign frameStart = start_q;
   assign frameDone  = done_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_pong_pixel_scanner.sv
// Scoreboard bench for pong_pixel_scanner on a reduced 24x32 raster so several
// full frames fit in a short run; test coordinates are scaled to that raster.
module tb_pong_pixel_scanner;

   localparam int W      = 24;
   localparam int H      = 32;
   localparam int NPIX   = W * H;           // 768
   localparam int FRAME_EDGES = NPIX * 2 + 1;  // 1537 with DRAW_LATENCY = 1
   localparam int LIMIT  = 4000;

   typedef struct packed {
      logic [7:0]  x;
      logic [8:0]  y;
      logic [15:0] c;
   } pix_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        frameRequest;
   logic        drawBall;
   logic        drawPaddle;
   logic        pixelReady;
   logic [7:0]  xCount;
   logic [8:0]  yCount;
   logic        pixelWrite;
   logic [15:0] pixelData;
   logic        frameStart;
   logic        frameDone;
   logic        busy;
   logic        render_en;

   pix_t exp_q[$];
   pix_t mon_e;
   int   checks = 0;
   int   errors = 0;
   int   xfer_cnt = 0;
   int   start_cnt = 0;
   int   done_cnt = 0;
   logic [7:0] last_x;
   logic [8:0] last_y;

   pong_pixel_scanner #(
      .WIDTH(W), .HEIGHT(H), .DRAW_LATENCY(1),
      .BALL_COLOUR(16'hFFFF), .PADDLE_COLOUR(16'h07E0), .BG_COLOUR(16'h0000)
   ) dut (
      .clock(clock), .reset(reset), .frameRequest(frameRequest),
      .drawBall(drawBall), .drawPaddle(drawPaddle), .pixelReady(pixelReady),
      .xCount(xCount), .yCount(yCount), .pixelWrite(pixelWrite),
      .pixelData(pixelData), .frameStart(frameStart), .frameDone(frameDone),
      .busy(busy)
   );

   always #5 clock = ~clock;

   // Renderer model: ball at (12,16); paddle covers (12,16) and (5,10).
   assign drawBall   = render_en && xCount == 8'd12 && yCount == 9'd16;
   assign drawPaddle = render_en && ((xCount == 8'd12 && yCount == 9'd16) ||
                                     (xCount == 8'd5  && yCount == 9'd10));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push_frame(input logic render);
      pix_t p;
      for (int yi = 0; yi < H; yi++) begin
         for (int xi = 0; xi < W; xi++) begin
            p.x = 8'(xi);
            p.y = 9'(yi);
            p.c = 16'h0000;
            if (render && xi == 12 && yi == 16)
               p.c = 16'hFFFF;
            else if (render && xi == 5 && yi == 10)
               p.c = 16'h07E0;
            exp_q.push_back(p);
         end
      end
   endtask

   task automatic request();
      frameRequest = 1'b1;
      @(posedge clock); #1;
      frameRequest = 1'b0;
      check("start_pulse", 32'(frameStart), 32'd1);
      check("start_busy", 32'(busy), 32'd1);
      check("start_coord", 32'({xCount, yCount}), 32'd0);
   endtask

   task automatic wait_for(input string name, input logic [7:0] x, input logic [8:0] y,
                           input logic pw);
      int n = 0;
      logic found = 1'b0;
      while (n < LIMIT && !found) begin
         if (xCount == x && yCount == y && pixelWrite == pw)
            found = 1'b1;
         else begin
            @(posedge clock); #1;
            n++;
         end
      end
      check(name, 32'(found), 32'd1);
   endtask

   task automatic run_to_done(input logic poke);
      int n = 0;
      while (n < LIMIT && frameDone !== 1'b1) begin
         @(posedge clock); #1;
         n++;
      end
      check("frame_done_seen", 32'(frameDone), 32'd1);
      if (poke) frameRequest = 1'b1;
      @(posedge clock); #1;
      frameRequest = 1'b0;
      check("done_one_cycle", 32'(frameDone), 32'd0);
      check("idle_after_done", 32'(busy), 32'd0);
      @(posedge clock); #1;
      check("late_request_ignored", 32'({busy, frameStart}), 32'd0);
   endtask

   // Monitor: a transfer happens on the coming edge when pixelWrite and pixelReady are both high.
   initial begin
      forever begin
         @(negedge clock);
         if (reset === 1'b0 && pixelWrite === 1'b1 && pixelReady === 1'b1) begin
            xfer_cnt++;
            last_x = xCount;
            last_y = yCount;
            if (exp_q.size() == 0) begin
               check("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
               mon_e = exp_q.pop_front();
               check("pix_x", 32'(xCount), 32'(mon_e.x));
               check("pix_y", 32'(yCount), 32'(mon_e.y));
               check("pix_data", 32'(pixelData), 32'(mon_e.c));
            end
         end
         if (frameStart === 1'b1) start_cnt++;
         if (frameDone === 1'b1) done_cnt++;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1);
   end

   initial begin
      int n;
      reset = 1'b1;
      frameRequest = 1'b0;
      pixelReady = 1'b1;
      render_en = 1'b0;

      // Reset state
      repeat (5) @(posedge clock);
      #1 reset = 1'b0;
      repeat (5) @(posedge clock);
      #1;
      check("rst_x", 32'(xCount), 32'd0);
      check("rst_y", 32'(yCount), 32'd0);
      check("rst_write", 32'(pixelWrite), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(frameDone), 32'd0);
      check("rst_start", 32'(frameStart), 32'd0);
      check("rst_data", 32'(pixelData), 32'h0000);

      // Frame 1: background only, latency of frameDone from the sampling edge
      push_frame(1'b0);
      request();
      n = 0;
      while (n < LIMIT && frameDone !== 1'b1) begin
         @(posedge clock); #1;
         n++;
      end
      check("done_latency", 32'(n), 32'(FRAME_EDGES));
      @(posedge clock); #1;
      check("f1_done_pulse", 32'(frameDone), 32'd0);
      check("f1_busy_low", 32'(busy), 32'd0);
      check("f1_starts", 32'(start_cnt), 32'd1);
      check("f1_dones", 32'(done_cnt), 32'd1);
      check("f1_transfers", 32'(xfer_cnt), 32'(NPIX));
      check("f1_last_x", 32'(last_x), 32'(W - 1));
      check("f1_last_y", 32'(last_y), 32'(H - 1));
      check("f1_sb_empty", 32'(exp_q.size()), 32'd0);

      // Frame 2: colour priority, backpressure, ignored requests, row wrap
      render_en = 1'b1;
      push_frame(1'b1);
      request();
      wait_for("reach_3_0", 8'd3, 9'd0, 1'b0);
      pixelReady = 1'b0;
      @(posedge clock); #1;
      for (int i = 0; i < 4; i++) begin
         check("stall_write", 32'(pixelWrite), 32'd1);
         check("stall_coord", 32'({xCount, yCount}), 32'({8'd3, 9'd0}));
         check("stall_data", 32'(pixelData), 32'h0000);
         if (i < 3) begin
            @(posedge clock); #1;
         end
      end
      pixelReady = 1'b1;
      @(posedge clock); #1;
      check("after_stall_x", 32'(xCount), 32'd4);
      check("after_stall_write", 32'(pixelWrite), 32'd0);
      frameRequest = 1'b1;
      @(posedge clock); #1;
      frameRequest = 1'b0;
      wait_for("reach_row_end", 8'(W - 1), 9'd0, 1'b1);
      @(posedge clock); #1;
      check("row_wrap", 32'({xCount, yCount}), 32'({8'd0, 9'd1}));
      run_to_done(1'b1);
      check("f2_starts", 32'(start_cnt), 32'd2);
      check("f2_dones", 32'(done_cnt), 32'd2);
      check("f2_sb_empty", 32'(exp_q.size()), 32'd0);

      // Frame 3: aborted by reset at (10,20); 20*24+10 = 490 pixels already sent
      render_en = 1'b0;
      push_frame(1'b0);
      request();
      wait_for("reach_10_20", 8'd10, 9'd20, 1'b0);
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_coord", 32'({xCount, yCount}), 32'd0);
      check("abort_write", 32'(pixelWrite), 32'd0);
      check("abort_data", 32'(pixelData), 32'h0000);
      check("abort_remaining", 32'(exp_q.size()), 32'd278);
      exp_q.delete();
      repeat (20) @(posedge clock);
      #1;
      check("abort_no_done", 32'(done_cnt), 32'd2);
      check("abort_idle", 32'(busy), 32'd0);

      // Frame 4: restart from (0,0) after abort
      render_en = 1'b1;
      push_frame(1'b1);
      request();
      run_to_done(1'b0);
      check("f4_starts", 32'(start_cnt), 32'd4);
      check("f4_dones", 32'(done_cnt), 32'd3);
      check("f4_sb_empty", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pong_pixel_scanner.md
Name: pong_pixel_scanner

Overview:
- Raster scan master for the Pong display path. Generates the xCount/yCount coordinates that the object renderers (ball, paddles) consume.
- Samples their draw flags back, resolves pixel colour by priority, and pushes one colour word per pixel to the LCD write interface using a valid/ready handshake.
- One frame is scanned per frameRequest pulse, and completion is signalled with frameDone.

Parameters:
- WIDTH, 240, pixels per row; xCount range is 0..WIDTH-1.
- HEIGHT, 320, rows per frame; yCount range is 0..HEIGHT-1.
- DRAW_LATENCY, 1, clock cycles (>=1) from stable coordinates until the drawBall/drawPaddle inputs are valid.
- BALL_COLOUR, 16'hFFFF, RGB565 colour for ball pixels.
- PADDLE_COLOUR, 16'h07E0, RGB565 colour for paddle pixels.
- BG_COLOUR, 16'h0000, RGB565 colour for background pixels.

Ports:
- clock  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- frameRequest  in  1  starts one frame scan; sampled only in IDLE.
- drawBall  in  1  ball renderer flag for the current coordinates.
- drawPaddle  in  1  paddle renderer flag for the current coordinates.
- pixelReady  in  1  LCD side can accept a pixel.
- xCount  out  8  current column.
- yCount  out  9  current row.
- pixelWrite  out  1  pixelData is valid.
- pixelData  out  16  RGB565 colour word.
- frameStart  out  1  one-cycle pulse when a scan begins.
- frameDone  out  1  one-cycle pulse after the last pixel is accepted.
- busy  out  1  high in every state except IDLE.

Behaviour:
- All outputs are registered.
- Reset values: state IDLE, xCount 0, yCount 0, pixelWrite 0, pixelData BG_COLOUR, frameStart 0, frameDone 0, busy 0, settle counter 0.
- Reset asserted mid-frame aborts the scan. Those values apply at the next edge, and no frameDone is emitted.
- State IDLE:
  - On frameRequest=1, go to SETTLE with xCount=0, yCount=0, settle counter 0.
  - frameStart=1 in the first SETTLE cycle.
- State SETTLE:
  - Coordinates are held stable.
  - The counter increments each cycle. After DRAW_LATENCY cycles in SETTLE, go to WRITE.
  - On that transition edge, pixelData is loaded from the draw flags sampled in the last SETTLE cycle, using the priority: drawBall gives BALL_COLOUR, else drawPaddle gives PADDLE_COLOUR, else BG_COLOUR.
  - pixelWrite is set to 1.
- State WRITE:
  - pixelWrite=1. pixelData, xCount and yCount are held constant until a transfer.
  - A transfer occurs on any cycle where pixelWrite=1 and pixelReady=1.
  - pixelReady=0 stalls indefinitely with no change.
  - On transfer with xCount<WIDTH-1: xCount+1, clear pixelWrite, go to SETTLE.
  - On transfer with xCount=WIDTH-1 and yCount<HEIGHT-1: xCount=0, yCount+1, go to SETTLE.
  - On transfer at (WIDTH-1, HEIGHT-1): clear pixelWrite, go to FRAME_END.
- State FRAME_END:
  - frameDone=1 for exactly one cycle.
  - xCount=0, yCount=0, then go to IDLE.
- pixelReady while pixelWrite=0 is ignored.
- frameRequest in any state other than IDLE is ignored, not queued.
- A frameRequest asserted in the same cycle frameDone is high is also ignored, because the state is FRAME_END.
- Throughput:
  - Each pixel costs DRAW_LATENCY+1 cycles when pixelReady is held high.
  - frameDone rises WIDTH*HEIGHT*(DRAW_LATENCY+1)+1 edges after the edge that samples frameRequest.
  - With defaults this is 153601.
- Arithmetic:
  - Coordinates never exceed WIDTH-1 / HEIGHT-1.
  - Wrap-around occurs only via the row and frame rules above; there is no modular overflow.
  - The settle counter is sized as clog2(DRAW_LATENCY+1).

Test Plan:
- Reset: hold reset 5 cycles, release, idle 5 cycles -> xCount=0, yCount=0, pixelWrite=0, busy=0, frameDone=0, pixelData=16'h0000.
- Full frame, pixelReady=1, draw flags 0, one-cycle frameRequest:
  - frameStart pulses once.
  - Exactly 76800 transfers occur, all 16'h0000.
  - The last transfer is at (239,319).
  - frameDone pulses exactly 153601 edges after the request, then busy=0.
- Colour priority: renderer model asserts drawBall at (120,160), drawPaddle at (120,160) and (5,10).
  - The pixel at (120,160) is 16'hFFFF.
  - The pixel at (5,10) is 16'h07E0.
  - Neighbours are 16'h0000.
- Backpressure: pixelReady=0 for 4 cycles during the WRITE of (3,0).
  - pixelWrite stays 1, and pixelData/xCount/yCount are unchanged.
  - On pixelReady=1, one transfer occurs, then xCount=4.
- Row wrap: observe the transfer at (239,0) -> next coordinates are (0,1).
- Abort and ignored request:
  - frameRequest pulsed mid-frame has no effect on the scan or the frame count.
  - Reset asserted at (50,100) -> next cycle IDLE, coordinates (0,0), pixelWrite=0, no frameDone.
  - A new frameRequest then restarts the scan from (0,0).
